// File: rtl/div8u4u_seq_if.sv
// Start/done handshake and result bus of the 8/4 sequential divider.
// The requester drives start and operands; the divider returns busy/done and results.
interface div8u4u_seq_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       dz;
  logic       ovf;
  logic       chk_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz, ovf, chk_err
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz, ovf, chk_err
  );
endinterface

// File: rtl/div8u4u_seq.sv
// Restoring divider, 8-bit dividend by 4-bit divisor, one quotient bit per clock,
// with divide-by-zero / overflow detection and a re-multiply self-check of each result.
module div8u4u_seq (
  input  logic              clk,
  input  logic              rst,
  div8u4u_seq_if.slave      bus,
  output logic [1:0]        dbg_state
);

  // Handshake: start is accepted only at an edge where the FSM is IDLE and start=1;
  // busy is high in CALC and DONE, done is a one-cycle pulse in DONE, and results
  // stay valid from done until the next accepted start.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q,     state_d;
  logic [7:0] dividend_q,  dividend_d;
  logic [3:0] divisor_q,   divisor_d;
  logic [4:0] prem_q,      prem_d;
  logic [3:0] qbits_q,     qbits_d;
  logic [1:0] idx_q,       idx_d;
  logic [3:0] quotient_q,  quotient_d;
  logic [3:0] remainder_q, remainder_d;
  logic       dz_q,        dz_d;
  logic       ovf_q,       ovf_d;
  logic       chk_err_q,   chk_err_d;

  logic [4:0] step_t;
  logic       step_ge;
  logic [4:0] step_rem;
  logic [3:0] step_q;
  logic [7:0] chk_prod;
  logic [7:0] chk_sum;

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    step_t   = {prem_q[3:0], dividend_q[idx_q]};
    step_ge  = (step_t >= {1'b0, divisor_q});
    step_rem = step_ge ? (step_t - {1'b0, divisor_q}) : step_t;
    step_q   = {qbits_q[2:0], step_ge};
    chk_prod = {4'b0000, step_q} * {4'b0000, divisor_q};
    chk_sum  = chk_prod + {4'b0000, step_rem[3:0]};
  end

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    prem_d      = prem_q;
    qbits_d     = qbits_q;
    idx_d       = idx_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    chk_err_d   = chk_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dividend_d = bus.dividend;
          divisor_d  = bus.divisor;
          dz_d       = 1'b0;
          ovf_d      = 1'b0;
          chk_err_d  = 1'b0;
          if (bus.divisor == 4'd0) begin
            dz_d        = 1'b1;
            quotient_d  = 4'hF;
            remainder_d = 4'h0;
            state_d     = ST_DONE;
          end else if (bus.dividend[7:4] >= bus.divisor) begin
            // A high nibble >= divisor means the true quotient needs more than 4 bits.
            ovf_d       = 1'b1;
            quotient_d  = 4'hF;
            remainder_d = 4'h0;
            state_d     = ST_DONE;
          end else begin
            prem_d  = {1'b0, bus.dividend[7:4]};
            qbits_d = 4'd0;
            idx_d   = 2'd3;
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        prem_d  = step_rem;
        qbits_d = step_q;
        idx_d   = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          quotient_d  = step_q;
          remainder_d = step_rem[3:0];
          chk_err_d   = (chk_sum != dividend_q);
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dividend_q  <= 8'd0;
      divisor_q   <= 4'd0;
      prem_q      <= 5'd0;
      qbits_q     <= 4'd0;
      idx_q       <= 2'd0;
      quotient_q  <= 4'd0;
      remainder_q <= 4'd0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      chk_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      prem_q      <= prem_d;
      qbits_q     <= qbits_d;
      idx_q       <= idx_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      chk_err_q   <= chk_err_d;
    end
  end

  assign bus.busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;
  assign bus.chk_err   = chk_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_div8u4u_seq.sv
// Bench for div8u4u_seq: directed cases, handshake/reset cases, an exhaustive (D,V)
// sweep and randomized operations with input noise, all checked against an arithmetic model.
module tb_div8u4u_seq;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_tests;
  int         n_fail;
  logic [10:0] exp_q[$];

  div8u4u_seq_if bus ();

  div8u4u_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Packed as {quotient, remainder, dz, ovf, chk_err}.
  function automatic logic [10:0] ref_model(input int d, input int v);
    int q, r;
    logic [3:0] q4, r4;
    if (v == 0) return {4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
    q = d / v;
    r = d % v;
    if (q > 15) return {4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
    q4 = q[3:0];
    r4 = r[3:0];
    return {q4, r4, 3'b000};
  endfunction

  // Called at a sample point (#1 after an edge) with the DUT in IDLE.
  // mask bit k raises start (and scrambles operands if nonzero) at sample k after acceptance.
  task automatic run_op(input logic [7:0] d, input logic [3:0] v, input logic [31:0] mask);
    int lat, busy_cnt, exp_lat;
    logic got;
    logic [10:0] e;
    exp_q.push_back(ref_model(int'(d), int'(v)));
    bus.start    = 1'b1;
    bus.dividend = d;
    bus.divisor  = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    got = 1'b0;
    while (lat <= 20) begin
      busy_cnt += int'(bus.busy);
      bus.start = mask[lat];
      if (mask != 0) begin
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
      end
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
    end
    check("done_seen", got, 1);
    e = exp_q.pop_front();
    exp_lat = (e[2] || e[1]) ? 1 : 5;
    if (got) begin
      check("latency", lat, exp_lat);
      check("busy_cycles", busy_cnt, exp_lat);
      check("quotient", bus.quotient, e[10:7]);
      check("remainder", bus.remainder, e[6:3]);
      check("dz", bus.dz, e[2]);
      check("ovf", bus.ovf, e[1]);
      check("chk_err", bus.chk_err, e[0]);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("done_one_cycle", bus.done, 0);
    check("busy_after_done", bus.busy, 0);
    check("quotient_hold", bus.quotient, e[10:7]);
    check("remainder_hold", bus.remainder, e[6:3]);
  endtask

  initial begin
    int dcnt;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dz", bus.dz, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_chk_err", bus.chk_err, 0);
    check("rst_state", dbg_state, 0);

    // Directed cases
    run_op(8'd200, 4'd13, 0);
    run_op(8'd225, 4'd15, 0);
    run_op(8'd0,   4'd1,  0);
    run_op(8'd9,   4'd10, 0);
    run_op(8'd240, 4'd15, 0);
    run_op(8'd77,  4'd0,  0);

    // Start pulses while busy and during the done cycle are ignored
    run_op(8'd200, 4'd13, (32'd1 << 2) | (32'd1 << 5));
    dcnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      dcnt += int'(bus.done);
    end
    check("no_extra_done", dcnt, 0);
    check("result_unchanged_q", bus.quotient, 15);
    check("result_unchanged_r", bus.remainder, 5);
    run_op(8'd100, 4'd7, 0);

    // Reset two cycles into CALC aborts the operation
    bus.start = 1'b1;
    bus.dividend = 8'd150;
    bus.divisor  = 4'd11;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_quotient", bus.quotient, 0);
    check("midrst_remainder", bus.remainder, 0);
    check("midrst_flags", {bus.dz, bus.ovf, bus.chk_err}, 0);
    dcnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      dcnt += int'(bus.done);
    end
    check("midrst_no_done", dcnt, 0);
    run_op(8'd45, 4'd6, 0);

    // Exhaustive sweep, back-to-back
    for (int d = 0; d < 256; d++) begin
      for (int v = 0; v < 16; v++) begin
        run_op(8'(d), 4'(v), 0);
      end
    end

    // Random operations with noisy start/operands while busy
    for (int k = 0; k < 200; k++) begin
      run_op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), $urandom);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
